// File: rtl/branch_resolve_if.sv
// Branch-resolve bus: IF-side BHT lookup plus the EX-stage branch fields,
// and the resolve results (outcome, flush/redirect, performance counters).
interface branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc_IF;
  logic             prediction_IF;
  logic             branch_ID_EX;
  logic [31:0]      pc_ID_EX;
  logic [31:0]      imm_data_ID_EX;
  logic [31:0]      op_a_EX;
  logic [31:0]      op_b_EX;
  logic [2:0]       func3_ID_EX;
  logic             prediction_ID_EX;
  logic             taken_EX;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  // Pipeline side: supplies fetch PC and EX branch fields, consumes results.
  modport master (
    output pc_IF, branch_ID_EX, pc_ID_EX, imm_data_ID_EX, op_a_EX, op_b_EX,
           func3_ID_EX, prediction_ID_EX,
    input  prediction_IF, taken_EX, flush, redirect_valid, redirect_pc,
           branch_count, mispredict_count
  );

  // Branch resolve unit side.
  modport slave (
    input  pc_IF, branch_ID_EX, pc_ID_EX, imm_data_ID_EX, op_a_EX, op_b_EX,
           func3_ID_EX, prediction_ID_EX,
    output prediction_IF, taken_EX, flush, redirect_valid, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: 2-bit BHT lookup for fetch, branch condition
// evaluation in EX, mispredict flush/redirect, BHT training and counters.
// A one-cycle SHADOW state after a mispredict ignores whatever sits in EX
// while the ID/EX clear takes effect.
module branch_resolve_unit #(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolve_if.slave   bus
);

  typedef enum logic {RUN, SHADOW} state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  bht [BHT_ENTRIES];

  logic             cond_true;
  logic             func3_legal;
  logic             resolve;
  logic             taken;
  logic             mispredict;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_cnt;

  // Fetch PC bits outside the index field carry no prediction information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_IF[31:IDX_W+2], bus.pc_IF[1:0]};

  // BHT read for fetch: pre-update value, no bypass from the EX write.
  assign bus.prediction_IF = bht[bus.pc_IF[IDX_W+1:2]][1];

  // Branch condition decode; reserved func3 encodings are not branches.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cond_true   = 1'b0;
    func3_legal = 1'b1;
    case (bus.func3_ID_EX)
      3'b000:  cond_true = (bus.op_a_EX == bus.op_b_EX);
      3'b001:  cond_true = (bus.op_a_EX != bus.op_b_EX);
      3'b100:  cond_true = ($signed(bus.op_a_EX) <  $signed(bus.op_b_EX));
      3'b101:  cond_true = ($signed(bus.op_a_EX) >= $signed(bus.op_b_EX));
      3'b110:  cond_true = (bus.op_a_EX <  bus.op_b_EX);
      3'b111:  cond_true = (bus.op_a_EX >= bus.op_b_EX);
      default: func3_legal = 1'b0;
    endcase
  end

  // Resolve is suppressed in SHADOW and while reset is asserted so the
  // flush/redirect outputs stay quiet during reset.
  assign resolve    = bus.branch_ID_EX & func3_legal & (state == RUN) & ~reset;
  assign taken      = resolve & cond_true;
  assign mispredict = resolve & (taken != bus.prediction_ID_EX);

  assign bus.taken_EX       = taken;
  assign bus.flush          = mispredict;
  assign bus.redirect_valid = mispredict;
  assign bus.redirect_pc    = taken ? (bus.pc_ID_EX + bus.imm_data_ID_EX)
                                    : (bus.pc_ID_EX + 32'd4);

  assign upd_idx = bus.pc_ID_EX[IDX_W+1:2];
  assign upd_cnt = bht[upd_idx];

  // BHT training and performance counters on each resolved branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is a small flop array, so it is reset in place to
      // weakly-not-taken rather than left to power-up contents.
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
      bus.branch_count     <= '0;
      bus.mispredict_count <= '0;
    end else if (resolve) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, matching the no-bypass read above.
      if (taken && upd_cnt != 2'b11) begin
        bht[upd_idx] <= upd_cnt + 2'b01;
      end else if (!taken && upd_cnt != 2'b00) begin
        bht[upd_idx] <= upd_cnt - 2'b01;
      end
      bus.branch_count     <= bus.branch_count + 1'b1;
      bus.mispredict_count <= bus.mispredict_count + CNT_W'(mispredict);
    end
  end

  // RUN/SHADOW state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: one SHADOW cycle after each mispredict.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mispredict) state_next = SHADOW;
      SHADOW:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of expected
// combinational outputs and an independent BHT/counter model.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset;

  branch_resolve_if #(.CNT_W(32)) bus ();

  branch_resolve_unit #(
    .BHT_ENTRIES(16),
    .IDX_W      (4),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        taken;
    logic        flush;
    logic [31:0] rpc;
    logic        pred_if;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  m_bht [16];
  logic        m_shadow;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb_v;
    sa   = a;
    sb_v = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb_v;
      3'b101:  return !(sa < sb_v);
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_shadow = 1'b0;
    m_br     = '0;
    m_mp     = '0;
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "/taken"},    32'(bus.taken_EX),       32'(e.taken));
      check({e.tag, "/flush"},    32'(bus.flush),          32'(e.flush));
      check({e.tag, "/redir_v"},  32'(bus.redirect_valid), 32'(e.flush));
      check({e.tag, "/redir_pc"}, bus.redirect_pc,         e.rpc);
      check({e.tag, "/pred_if"},  32'(bus.prediction_IF),  32'(e.pred_if));
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, let the edge
  // happen, then advance the model to match the post-edge state.
  task automatic br(input logic rst_v, input logic bv, input logic [31:0] pc,
                    input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] f3, input logic pred, input logic [31:0] pcif,
                    input string tag);
    exp_t e;
    logic res, tk, mp;
    int   idx;
    @(negedge clk);
    reset                = rst_v;
    bus.branch_ID_EX     = bv;
    bus.pc_ID_EX         = pc;
    bus.imm_data_ID_EX   = imm;
    bus.op_a_EX          = a;
    bus.op_b_EX          = b;
    bus.func3_ID_EX      = f3;
    bus.prediction_ID_EX = pred;
    bus.pc_IF            = pcif;
    res = bv && m_legal(f3) && !m_shadow && !rst_v;
    tk  = res && m_cond(f3, a, b);
    mp  = res && (tk != pred);
    e.tag     = tag;
    e.taken   = tk;
    e.flush   = mp;
    e.rpc     = tk ? pc + imm : pc + 32'd4;
    e.pred_if = m_bht[pcif[5:2]][1];
    sb.push_back(e);
    #1;
    compare_outputs();
    @(posedge clk);
    #1;
    if (rst_v) begin
      model_reset();
    end else begin
      if (res) begin
        idx = int'(pc[5:2]);
        if (tk  && m_bht[idx] < 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
        if (!tk && m_bht[idx] > 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
        m_br = m_br + 1;
        if (mp) m_mp = m_mp + 1;
      end
      m_shadow = mp;
    end
  endtask

  task automatic idle(input logic [31:0] pcif, input string tag);
    br(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, pcif, tag);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "/branch_count"},     bus.branch_count,     m_br);
    check({tag, "/mispredict_count"}, bus.mispredict_count, m_mp);
  endtask

  initial begin
    logic [31:0] pool [5];
    pool[0] = 32'h0;
    pool[1] = 32'h5;
    pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h1;
    pool[4] = 32'h8000_0000;
    model_reset();

    // Reset, then every BHT entry predicts not-taken.
    br(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, "reset0");
    br(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, "reset1");
    check_counts("after_reset");
    for (int i = 0; i < 16; i++) idle(32'(i * 4), $sformatf("sweep%0d", i));

    // beq taken but predicted not-taken: flush + redirect to 0x120.
    br(1'b0, 1'b1, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 1'b0, 32'h100, "beq_mp");
    // Held in SHADOW: ignored; trained counter now predicts taken.
    br(1'b0, 1'b1, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 1'b0, 32'h100, "beq_shadow");
    check_counts("after_shadow");
    // Resolved normally on the following cycle.
    br(1'b0, 1'b1, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 1'b1, 32'h100, "beq_again");
    check_counts("after_beq_again");

    // Signed vs unsigned compare on the same operands.
    br(1'b0, 1'b1, 32'h204, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b1, 32'h204, "blt");
    br(1'b0, 1'b1, 32'h204, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b1, 32'h204, "bltu");
    idle(32'h204, "bltu_shadow");
    br(1'b0, 1'b1, 32'h208, 32'h40, 32'h3, 32'h3, 3'b101, 1'b1, 32'h208, "bge");
    br(1'b0, 1'b1, 32'h20C, 32'h40, 32'h2, 32'h3, 3'b111, 1'b0, 32'h20C, "bgeu_nt");
    br(1'b0, 1'b1, 32'h210, 32'h8,  32'h2, 32'h3, 3'b001, 1'b1, 32'h210, "bne");
    check_counts("after_types");

    // Saturation at index 5: four taken, then four not-taken, then recovery.
    for (int i = 0; i < 4; i++)
      br(1'b0, 1'b1, 32'h14, 32'h10, 32'h7, 32'h7, 3'b000, 1'b1, 32'h14, $sformatf("sat_up%0d", i));
    idle(32'h14, "sat_top");
    for (int i = 0; i < 4; i++)
      br(1'b0, 1'b1, 32'h14, 32'h10, 32'h7, 32'h7, 3'b001, 1'b0, 32'h14, $sformatf("sat_dn%0d", i));
    idle(32'h14, "sat_bottom");
    br(1'b0, 1'b1, 32'h14, 32'h10, 32'h7, 32'h7, 3'b000, 1'b1, 32'h14, "rise0");
    br(1'b0, 1'b1, 32'h14, 32'h10, 32'h7, 32'h7, 3'b000, 1'b1, 32'h14, "rise1");
    idle(32'h14, "rise_check");
    check_counts("after_sat");

    // Reserved func3 is not a branch.
    br(1'b0, 1'b1, 32'h100, 32'h20, 32'h5, 32'h5, 3'b010, 1'b0, 32'h100, "func3_010");
    br(1'b0, 1'b1, 32'h100, 32'h20, 32'h5, 32'h6, 3'b011, 1'b1, 32'h100, "func3_011");
    check_counts("after_illegal");

    // Mixed traffic from a small operand pool.
    for (int i = 0; i < 24; i++)
      br(1'b0, 1'b1, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, {24'h0, 8'($urandom_range(0, 255))},
         pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $sformatf("mix%0d", i));
    check_counts("after_mix");

    // Reset asserted during a would-be mispredict: outputs quiet, all cleared.
    br(1'b1, 1'b1, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 1'b0, 32'h100, "reset_mp");
    check_counts("after_mid_reset");
    for (int i = 0; i < 16; i++) idle(32'(i * 4), $sformatf("resweep%0d", i));
    // State is RUN: an immediate mispredict resolves; entry trains 01 -> 10.
    br(1'b0, 1'b1, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 1'b0, 32'h100, "post_reset_mp");
    idle(32'h100, "post_reset_pred");
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage closing end of the branch-prediction path.
- IF side: holds a 2-bit branch history table (BHT) and supplies prediction_IF, which travels through IF/ID and ID/EX.
- EX side: consumes the ID/EX branch fields, evaluates the branch condition and compares the outcome against prediction_ID_EX.
- On a mismatch it issues a flush (driving the clear input of the IF/ID and ID/EX registers) and a PC redirect; on every resolved branch it trains the BHT.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit saturating counters; power of two.
- IDX_W, 4, log2(BHT_ENTRIES); index = pc[IDX_W+1:2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_IF  in  32  fetch PC used for the BHT lookup.
- prediction_IF  out  1  predicted-taken for pc_IF (MSB of the indexed counter).
- branch_ID_EX  in  1  conditional-branch instruction valid in EX.
- pc_ID_EX  in  32  PC of the EX instruction.
- imm_data_ID_EX  in  32  sign-extended B-type offset.
- op_a_EX  in  32  forwarded rs1 value.
- op_b_EX  in  32  forwarded rs2 value.
- func3_ID_EX  in  3  branch type.
- prediction_ID_EX  in  1  prediction carried with the instruction.
- taken_EX  out  1  resolved outcome.
- flush  out  1  clear for IF/ID and ID/EX.
- redirect_valid  out  1  PC mux select.
- redirect_pc  out  32  corrected fetch address.
- branch_count  out  CNT_W  resolved branches.
- mispredict_count  out  CNT_W  mispredictions.

Behaviour:
- Reset (synchronous, active-high):
  - Every BHT entry = 2'b01 (weakly not-taken).
  - branch_count = 0, mispredict_count = 0, state = RUN.
  - Combinational outputs during reset: flush = 0, redirect_valid = 0, taken_EX = 0.
- BHT read: combinational, prediction_IF = bht[pc_IF[IDX_W+1:2]][1].
- Condition decode (func3):
  - 000 beq: a==b
  - 001 bne: a!=b
  - 100 blt: signed a<b
  - 101 bge: signed a>=b
  - 110 bltu: unsigned a<b
  - 111 bgeu: unsigned a>=b
  - 010/011: treated as not a branch. No resolve, no train, no count.
- Resolve condition: resolve = branch_ID_EX & legal func3 & (state==RUN).
- Mispredict: mispredict = resolve & (taken_EX != prediction_ID_EX). taken_EX is 0 when resolve=0.
- Same-cycle combinational outputs:
  - flush = redirect_valid = mispredict.
  - redirect_pc = taken_EX ? pc_ID_EX+imm_data_ID_EX : pc_ID_EX+4.
  - All adds are 32-bit with wrap-around; no overflow flag.
- On the clock edge when resolve=1:
  - bht[pc_ID_EX[IDX_W+1:2]] saturating +1 if taken (cap 11), -1 if not taken (floor 00).
  - branch_count += 1.
  - mispredict_count += mispredict.
  - Both counters wrap modulo 2^CNT_W.
- State machine, RUN / SHADOW:
  - RUN -> SHADOW on a mispredict.
  - SHADOW -> RUN unconditionally after one cycle.
  - In SHADOW, resolve is forced 0. This guards against wrong-path contents reaching EX while the ID/EX clear takes effect.
- Read/update collision (same index, same cycle): prediction_IF returns the pre-update value. There is no bypass.
- Reset mid-operation: reset wins over any update or state transition in the same cycle.
- Latency:
  - Flush and redirect appear in the same cycle the branch is in EX.
  - The BHT change is visible to prediction_IF the next cycle.

Test Plan:
- Reset, then sweep pc_IF 0x00..0x3C step 4 -> prediction_IF = 0 for every entry; both counters = 0.
- beq at pc 0x100, a=b=5, imm=0x20, prediction_ID_EX=0 -> taken_EX=1, flush=1, redirect_pc=0x120; next cycle bht[0] = 10, prediction_IF(0x100) = 1, mispredict_count = 1.
- Same branch again with branch_ID_EX=1 held in the cycle right after the mispredict -> ignored in SHADOW (no count, no train); resolved normally on the following cycle.
- blt a=0xFFFFFFFF, b=1 -> taken; bltu with the same operands -> not taken, redirect_pc = pc+4 when predicted taken.
- Four consecutive taken resolves at one index -> counter saturates at 11; four not-taken -> 00, never wraps.
- func3=010 with branch_ID_EX=1 -> no flush, counters unchanged. Separately, assert reset during a mispredict cycle -> counters = 0, all BHT entries = 01, state = RUN.
